ecap5_wbuart_rx: RTL and testbench
==================================

Name: ecap5_wbuart_rx

Overview:
Serial receive stage of the Wishbone UART. It sits directly downstream of the uart_rx_i pin and upstream of the Wishbone register/FIFO logic. It synchronises the asynchronous line, detects start bits, samples 8N1 frames at mid-bit using a programmable clock divider, and presents each received byte on a valid/ready interface with frame-error and overrun status.

Parameters:
- CLK_DIV_W, 16, width of the clocks-per-bit divider input.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous, active-high
- uart_rx_i  in  1  asynchronous serial line, idle high
- cfg_clk_div_i  in  CLK_DIV_W  clk_i cycles per bit; legal values >= 4
- data_o  out  8  received byte, LSB first on the line
- valid_o  out  1  data_o/frame_error_o hold a byte not yet consumed
- ready_i  in  1  consumer accepts the byte when valid_o && ready_i
- frame_error_o  out  1  stop bit of the byte on data_o sampled low
- overrun_o  out  1  one-cycle pulse: a byte was dropped because the output was full
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: data_o=0, valid_o=0, frame_error_o=0, overrun_o=0, busy_o=0, state=IDLE, synchroniser flops=1.
- Synchroniser: 2-FF chain to rx_s, plus a registered copy rx_q. Falling edge is rx_q=1 && rx_s=0.
- FSM states:
  - IDLE: on a falling edge, latch div=cfg_clk_div_i, cnt=0, go to START. cfg changes outside IDLE have no effect on the current frame.
  - START: cnt increments. At cnt==(div>>1)-1, sample rx_s. If rx_s=1 (glitch), return to IDLE. Otherwise cnt=0, bit_idx=0, go to DATA.
  - DATA: at cnt==div-1, shift rx_s into shreg MSB (LSB-first reception), cnt=0, bit_idx++. After bit_idx 7, go to STOP.
  - STOP: at cnt==div-1, sample the stop bit, deliver the byte, go to IDLE. IDLE is re-entered at mid-stop-bit, leaving half a bit of slack for resynchronisation.
- A break (line held low) does not retrigger: IDLE requires a high-to-low transition.
- Delivery in the cycle after the stop sample:
  - If valid_o=0, or valid_o && ready_i in that same cycle: data_o=shreg, frame_error_o=!stop, valid_o=1.
  - Otherwise keep the old byte, drop the new one, and pulse overrun_o for 1 cycle.
- Handshake: valid_o clears the cycle after valid_o && ready_i unless a new byte is delivered in that same cycle. data_o is stable while valid_o=1 and ready_i=0.
- Frame error: the byte is still delivered, with frame_error_o=1 alongside it.
- Latency: valid_o rises 1 cycle after the stop-bit sample. The stop-bit sample falls roughly 9.5 bit periods plus 3 cycles after the pin falling edge.
- Counter width: CLK_DIV_W. Behaviour for div<4 is unspecified.
- rst_i mid-frame: immediate return to reset state; any partial byte is discarded.

Optional Feature:
- Macro: ECAP5_WBUART_RX_PARITY_EN.
- With the macro:
  - Extra inputs cfg_parity_en_i (1) and cfg_parity_odd_i (1), plus output parity_error_o (1, held with data_o like frame_error_o).
  - When enabled (latched in IDLE), a PARITY state follows DATA, sampled at cnt==div-1.
  - parity_error_o = (^shreg ^ parity_bit) != cfg_parity_odd_i.
- Without the macro: those ports are absent, there is no PARITY state, and the frame is 8N1 only.

Decomposition:
- Package ecap5_wbuart_pkg:
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}
  - localparam RX_DATA_BITS=8
  - default CLK_DIV_W
- Shared by the future TX stage and the top-level ecap5_wbuart.
- One sub-module is natural: ecap5_wbuart_sync, the 2-FF synchroniser with reset value 1, reused by the top level for any other asynchronous inputs.

Test Plan:
1. div=16, send 0xA5 8N1, ready_i=1 -> data_o=0xA5, valid_o for 1 cycle, frame_error_o=0, overrun_o never asserted.
2. div=16, 4-cycle low glitch on an idle line -> returns to IDLE by the mid-start sample; valid_o stays 0 and busy_o drops.
3. div=16, send 0x3C with stop bit=0, then hold the line low 40 bit times -> one byte with frame_error_o=1 and no further frames until the line goes high then low.
4. ready_i=0, send 0x11 then 0x22 back-to-back -> data_o=0x11 with valid_o held; overrun_o pulses once; after ready_i=1, valid_o clears with no 0x22 delivered.
5. Assert rst_i during DATA bit 3 of 0x5A -> all outputs reset next cycle; a following 0x81 is received correctly.
6. (ECAP5_WBUART_RX_PARITY_EN) even parity on, send 0x07 with parity bit 1 -> parity_error_o=0; the same byte with parity bit 0 -> parity_error_o=1.

Source files
------------

// File: rtl/ecap5_wbuart_pkg.sv
// Shared types and constants for the Wishbone UART receive/transmit stages.
package ecap5_wbuart_pkg;

    localparam int RX_DATA_BITS      = 8;
    localparam int CLK_DIV_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // High when the received data plus parity bit disagree with the selected sense.
    function automatic logic parity_mismatch(
        input logic [RX_DATA_BITS-1:0] data,
        input logic                    parity_bit,
        input logic                    odd
    );
        return ((^data) ^ parity_bit) != odd;
    endfunction

endpackage

// File: rtl/ecap5_wbuart_sync.sv
// Two-flop synchroniser for asynchronous inputs; both stages reset to 1 (idle line level).
module ecap5_wbuart_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    // Metastability chain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            q_o    <= 1'b1;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/ecap5_wbuart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ready byte output.
// Optional parity support is enabled by defining ECAP5_WBUART_RX_PARITY_EN.
module ecap5_wbuart_rx
    import ecap5_wbuart_pkg::*;
#(
    parameter int CLK_DIV_W = CLK_DIV_W_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    uart_rx_i,
    input  logic [CLK_DIV_W-1:0]    cfg_clk_div_i,
`ifdef ECAP5_WBUART_RX_PARITY_EN
    input  logic                    cfg_parity_en_i,
    input  logic                    cfg_parity_odd_i,
    output logic                    parity_error_o,
`endif
    output logic [RX_DATA_BITS-1:0] data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    frame_error_o,
    output logic                    overrun_o,
    output logic                    busy_o
);

    localparam logic [CLK_DIV_W-1:0] CNT_ZERO = {CLK_DIV_W{1'b0}};
    localparam logic [CLK_DIV_W-1:0] CNT_ONE  = {{(CLK_DIV_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]           LAST_BIT = 3'(RX_DATA_BITS - 1);

    logic rx_s;
    logic rx_q;
    logic fall_s;
    logic bit_end_s;
    logic half_end_s;

    rx_state_t                state_q,   state_d;
    logic [CLK_DIV_W-1:0]     cnt_q,     cnt_d;
    logic [CLK_DIV_W-1:0]     div_q,     div_d;
    logic [2:0]               bit_idx_q, bit_idx_d;
    logic [RX_DATA_BITS-1:0]  shreg_q,   shreg_d;
    logic                     stop_q,    stop_d;
    logic                     pend_q,    pend_d;
    logic [RX_DATA_BITS-1:0]  data_q,    data_d;
    logic                     valid_q,   valid_d;
    logic                     ferr_q,    ferr_d;
    logic                     ovr_q,     ovr_d;
    logic                     busy_q,    busy_d;
`ifdef ECAP5_WBUART_RX_PARITY_EN
    logic                     par_en_q,  par_en_d;
    logic                     par_odd_q, par_odd_d;
    logic                     par_bit_q, par_bit_d;
    logic                     perr_q,    perr_d;
`endif

    ecap5_wbuart_sync u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (uart_rx_i),
        .q_o   (rx_s)
    );

    assign fall_s     = rx_q & ~rx_s;
    assign bit_end_s  = (cnt_q == (div_q - CNT_ONE));
    assign half_end_s = (cnt_q == ({1'b0, div_q[CLK_DIV_W-1:1]} - CNT_ONE));

    // Frame FSM: next state, bit counter and shift register
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        stop_d    = stop_q;
        pend_d    = 1'b0;
`ifdef ECAP5_WBUART_RX_PARITY_EN
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        par_bit_d = par_bit_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = CNT_ZERO;
                if (fall_s) begin
                    div_d   = cfg_clk_div_i;
                    state_d = START;
`ifdef ECAP5_WBUART_RX_PARITY_EN
                    par_en_d  = cfg_parity_en_i;
                    par_odd_d = cfg_parity_odd_i;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (half_end_s) begin
                    cnt_d = CNT_ZERO;
                    // A start bit that is high again at mid-bit was a glitch
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        bit_idx_d = 3'd0;
                        state_d   = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    shreg_d   = {rx_s, shreg_q[RX_DATA_BITS-1:1]};
                    cnt_d     = CNT_ZERO;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef ECAP5_WBUART_RX_PARITY_EN
                        if (par_en_q) begin
                            state_d = PARITY;
                        end else begin
                            state_d = STOP;
                        end
`else
                        state_d = STOP;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef ECAP5_WBUART_RX_PARITY_EN
            PARITY: begin
                if (bit_end_s) begin
                    par_bit_d = rx_s;
                    cnt_d     = CNT_ZERO;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            STOP: begin
                if (bit_end_s) begin
                    stop_d  = rx_s;
                    pend_d  = 1'b1;
                    cnt_d   = CNT_ZERO;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Output holding register: accept, drop with overrun, or clear on handshake
    always_comb begin
        data_d = data_q;
        valid_d = valid_q;
        ferr_d = ferr_q;
        ovr_d  = 1'b0;
`ifdef ECAP5_WBUART_RX_PARITY_EN
        perr_d = perr_q;
`endif
        if (pend_q) begin
            if (!valid_q || ready_i) begin
                data_d  = shreg_q;
                ferr_d  = ~stop_q;
                valid_d = 1'b1;
`ifdef ECAP5_WBUART_RX_PARITY_EN
                perr_d  = par_en_q & parity_mismatch(shreg_q, par_bit_q, par_odd_q);
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_q      <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            div_q     <= CNT_ZERO;
            bit_idx_q <= 3'd0;
            shreg_q   <= {RX_DATA_BITS{1'b0}};
            stop_q    <= 1'b0;
            pend_q    <= 1'b0;
            data_q    <= {RX_DATA_BITS{1'b0}};
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef ECAP5_WBUART_RX_PARITY_EN
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_q      <= rx_s;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            stop_q    <= stop_d;
            pend_q    <= pend_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
`ifdef ECAP5_WBUART_RX_PARITY_EN
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign data_o        = data_q;
    assign valid_o       = valid_q;
    assign frame_error_o = ferr_q;
    assign overrun_o     = ovr_q;
    assign busy_o        = busy_q;
`ifdef ECAP5_WBUART_RX_PARITY_EN
    assign parity_error_o = perr_q;
`endif

endmodule

// File: tb/tb_ecap5_wbuart_rx.sv
// Bench for ecap5_wbuart_rx: directed frames, frame-level delivery model, per-cycle compare.
module tb_ecap5_wbuart_rx;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        uart_rx_i;
    logic        ready_i;
    logic [15:0] cfg_clk_div_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        frame_error_o;
    logic        overrun_o;
    logic        busy_o;
`ifdef ECAP5_WBUART_RX_PARITY_EN
    logic        cfg_parity_en_i;
    logic        cfg_parity_odd_i;
    logic        parity_error_o;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mess_cfg = 1'b0;

    // Expected deliveries: cycle at which valid_o must show the byte
    int         arr_cyc_q[$];
    logic [7:0] arr_data_q[$];
    logic       arr_ferr_q[$];
    logic       arr_perr_q[$];

    logic       exp_valid = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    logic       exp_ferr  = 1'b0;
    logic       exp_perr  = 1'b0;
    logic       exp_ovr   = 1'b0;
    logic       s_rst;
    logic       s_ready;

    logic       prev_valid = 1'b0;
    int         rise_cyc   = 0;
    int         rise_cnt   = 0;
    int         ovr_cnt    = 0;
    logic [7:0] rise_data  = 8'h00;
    logic       rise_ferr  = 1'b0;
    logic       rise_perr  = 1'b0;

    always #5 clk = ~clk;

    ecap5_wbuart_rx #(.CLK_DIV_W(16)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .uart_rx_i       (uart_rx_i),
        .cfg_clk_div_i   (cfg_clk_div_i),
`ifdef ECAP5_WBUART_RX_PARITY_EN
        .cfg_parity_en_i (cfg_parity_en_i),
        .cfg_parity_odd_i(cfg_parity_odd_i),
        .parity_error_o  (parity_error_o),
`endif
        .data_o          (data_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .frame_error_o   (frame_error_o),
        .overrun_o       (overrun_o),
        .busy_o          (busy_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one frame starting at the current negedge; records the expected delivery.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int div,
                              input int par, output int fall);
        logic perr;
        cfg_clk_div_i = 16'(div);
        uart_rx_i     = 1'b0;
        fall          = cyc;
        perr          = 1'b0;
`ifdef ECAP5_WBUART_RX_PARITY_EN
        if (par >= 0) perr = (((^b) ^ par[0]) != cfg_parity_odd_i);
`endif
        // Stop sample is 3 sync/detect cycles + half a bit + 9 bits (+ parity); delivery one later
        arr_cyc_q.push_back(fall + 3 + div / 2 + 9 * div + ((par >= 0) ? div : 0) + 1);
        arr_data_q.push_back(b);
        arr_ferr_q.push_back(!stop_bit);
        arr_perr_q.push_back(perr);
        repeat (div) @(negedge clk);
        if (mess_cfg) cfg_clk_div_i = 16'd6;
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (div) @(negedge clk);
        end
        if (par >= 0) begin
            uart_rx_i = par[0];
            repeat (div) @(negedge clk);
        end
        uart_rx_i = stop_bit;
        repeat (div) @(negedge clk);
        cfg_clk_div_i = 16'(div);
    endtask

    // Model step and output compare, 1 time unit after each rising edge
    initial begin : model_compare
        forever begin
            @(posedge clk);
            s_rst   = rst_i;
            s_ready = ready_i;
            cyc     = cyc + 1;
            #1;
            if (s_rst) begin
                exp_valid = 1'b0;
                exp_data  = 8'h00;
                exp_ferr  = 1'b0;
                exp_perr  = 1'b0;
                exp_ovr   = 1'b0;
                arr_cyc_q.delete();
                arr_data_q.delete();
                arr_ferr_q.delete();
                arr_perr_q.delete();
            end else begin
                exp_ovr = 1'b0;
                if (arr_cyc_q.size() > 0 && arr_cyc_q[0] == cyc) begin
                    if (!exp_valid || s_ready) begin
                        exp_valid = 1'b1;
                        exp_data  = arr_data_q[0];
                        exp_ferr  = arr_ferr_q[0];
                        exp_perr  = arr_perr_q[0];
                    end else begin
                        exp_ovr = 1'b1;
                    end
                    void'(arr_cyc_q.pop_front());
                    void'(arr_data_q.pop_front());
                    void'(arr_ferr_q.pop_front());
                    void'(arr_perr_q.pop_front());
                end else if (exp_valid && s_ready) begin
                    exp_valid = 1'b0;
                end
            end
            check("valid_o", {31'd0, valid_o}, {31'd0, exp_valid});
            check("overrun_o", {31'd0, overrun_o}, {31'd0, exp_ovr});
            if (exp_valid) begin
                check("data_o", {24'd0, data_o}, {24'd0, exp_data});
                check("frame_error_o", {31'd0, frame_error_o}, {31'd0, exp_ferr});
`ifdef ECAP5_WBUART_RX_PARITY_EN
                check("parity_error_o", {31'd0, parity_error_o}, {31'd0, exp_perr});
`endif
            end
            if (valid_o === 1'b1 && prev_valid !== 1'b1) begin
                rise_cyc  = cyc;
                rise_cnt  = rise_cnt + 1;
                rise_data = data_o;
                rise_ferr = frame_error_o;
`ifdef ECAP5_WBUART_RX_PARITY_EN
                rise_perr = parity_error_o;
`endif
            end
            prev_valid = valid_o;
            if (overrun_o === 1'b1) ovr_cnt = ovr_cnt + 1;
        end
    end

    initial begin : stimulus
        int f;
        int r0;
        int o0;
        rst_i         = 1'b1;
        uart_rx_i     = 1'b1;
        ready_i       = 1'b1;
        cfg_clk_div_i = 16'd16;
`ifdef ECAP5_WBUART_RX_PARITY_EN
        cfg_parity_en_i  = 1'b0;
        cfg_parity_odd_i = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_data", {24'd0, data_o}, 32'd0);
        check("rst_ferr", {31'd0, frame_error_o}, 32'd0);
        check("rst_ovr", {31'd0, overrun_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        rst_i = 1'b0;
        repeat (5) @(negedge clk);

        // 1: plain 0xA5 at div=16
        send_frame(8'hA5, 1'b1, 16, -1, f);
        repeat (4) @(negedge clk);
        check("t1_rises", rise_cnt, 32'd1);
        check("t1_latency", rise_cyc - f, 32'd156);
        check("t1_data", {24'd0, rise_data}, 32'h0000_00A5);
        check("t1_ferr", {31'd0, rise_ferr}, 32'd0);
        check("t1_ovr_cnt", ovr_cnt, 32'd0);
        check("t1_valid_clr", {31'd0, valid_o}, 32'd0);

        // divider boundaries: minimum 4 and an odd value
        send_frame(8'hE1, 1'b1, 4, -1, f);
        repeat (4) @(negedge clk);
        check("div4_latency", rise_cyc - f, 32'd42);
        check("div4_data", {24'd0, rise_data}, 32'h0000_00E1);
        send_frame(8'h3F, 1'b1, 5, -1, f);
        repeat (4) @(negedge clk);
        check("div5_latency", rise_cyc - f, 32'd51);
        check("div5_data", {24'd0, rise_data}, 32'h0000_003F);

        // cfg change mid-frame must not disturb the frame in flight
        mess_cfg = 1'b1;
        send_frame(8'h69, 1'b1, 16, -1, f);
        mess_cfg = 1'b0;
        repeat (4) @(negedge clk);
        check("cfg_hold_data", {24'd0, rise_data}, 32'h0000_0069);
        check("cfg_hold_latency", rise_cyc - f, 32'd156);

        // 2: 4-cycle glitch
        r0 = rise_cnt;
        uart_rx_i = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx_i = 1'b1;
        repeat (2) @(negedge clk);
        check("t2_busy_mid", {31'd0, busy_o}, 32'd1);
        repeat (20) @(negedge clk);
        check("t2_busy_end", {31'd0, busy_o}, 32'd0);
        check("t2_no_byte", rise_cnt - r0, 32'd0);

        // 3: frame error followed by a long break
        r0 = rise_cnt;
        send_frame(8'h3C, 1'b0, 16, -1, f);
        repeat (40 * 16) @(negedge clk);
        check("t3_one_byte", rise_cnt - r0, 32'd1);
        check("t3_data", {24'd0, rise_data}, 32'h0000_003C);
        check("t3_ferr", {31'd0, rise_ferr}, 32'd1);
        check("t3_busy_break", {31'd0, busy_o}, 32'd0);
        uart_rx_i = 1'b1;
        repeat (32) @(negedge clk);
        send_frame(8'h96, 1'b1, 16, -1, f);
        repeat (4) @(negedge clk);
        check("t3_recover", {24'd0, rise_data}, 32'h0000_0096);
        check("t3_recover_ferr", {31'd0, rise_ferr}, 32'd0);

        // 4: overrun with consumer stalled
        ready_i = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, 16, -1, f);
        send_frame(8'h22, 1'b1, 16, -1, f);
        repeat (4) @(negedge clk);
        check("t4_held_valid", {31'd0, valid_o}, 32'd1);
        check("t4_held_data", {24'd0, data_o}, 32'h0000_0011);
        check("t4_ovr_once", ovr_cnt - o0, 32'd1);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        @(negedge clk);
        check("t4_valid_clr", {31'd0, valid_o}, 32'd0);
        repeat (4) @(negedge clk);
        check("t4_no_22", {31'd0, valid_o}, 32'd0);

        // 5: reset during data bit 3 of 0x5A, with a held byte pending
        send_frame(8'hC3, 1'b1, 16, -1, f);
        repeat (4) @(negedge clk);
        check("t5_pre_valid", {31'd0, valid_o}, 32'd1);
        uart_rx_i = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            uart_rx_i = f[0] ? 1'b0 : 1'b0;
            uart_rx_i = (i == 1) ? 1'b1 : 1'b0;
            repeat (16) @(negedge clk);
        end
        uart_rx_i = 1'b1;
        repeat (8) @(negedge clk);
        check("t5_busy_mid", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("t5_rst_valid", {31'd0, valid_o}, 32'd0);
        check("t5_rst_data", {24'd0, data_o}, 32'd0);
        check("t5_rst_ferr", {31'd0, frame_error_o}, 32'd0);
        check("t5_rst_busy", {31'd0, busy_o}, 32'd0);
        repeat (32) @(negedge clk);
        ready_i = 1'b1;
        r0 = rise_cnt;
        send_frame(8'h81, 1'b1, 16, -1, f);
        repeat (4) @(negedge clk);
        check("t5_after_rises", rise_cnt - r0, 32'd1);
        check("t5_after_data", {24'd0, rise_data}, 32'h0000_0081);

`ifdef ECAP5_WBUART_RX_PARITY_EN
        // 6: even parity on 0x07 (three ones)
        cfg_parity_en_i  = 1'b1;
        cfg_parity_odd_i = 1'b0;
        send_frame(8'h07, 1'b1, 16, 1, f);
        repeat (4) @(negedge clk);
        check("t6_latency", rise_cyc - f, 32'd172);
        check("t6_good_perr", {31'd0, rise_perr}, 32'd0);
        send_frame(8'h07, 1'b1, 16, 0, f);
        repeat (4) @(negedge clk);
        check("t6_bad_perr", {31'd0, rise_perr}, 32'd1);
        check("t6_bad_data", {24'd0, rise_data}, 32'h0000_0007);
        cfg_parity_en_i = 1'b0;
        repeat (4) @(negedge clk);
`endif

        check("queue_drained", arr_cyc_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
